// File: rtl/bsg_n_to_1_tagged_fifo.sv
// bsg_n_to_1_tagged_fifo
// Merges num_in_p ready/valid input channels onto one valid/yumi stream.
// Each output word carries the index of its source channel as a tag.
// Each channel is either buffered by a small private FIFO or, when its bit
// in unbuffered_mask_p is set, passed straight through to the arbiter.
// A locked round-robin arbiter keeps tag_o/data_o stable until yumi_i.
// Optional feature macro: BSG_N_TO_1_TAGGED_FIFO_COUNTERS_EN adds the
// per-channel saturating sent_count_o counters.

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

// Small circular-buffer FIFO with no bypass: a word written at one edge is
// visible on v_o/data_o only after that edge. A full FIFO stays not-ready
// even in a cycle in which it is being dequeued.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_width_lp = `BSG_SAFE_CLOG2(els_p);
    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);

    logic [els_p-1:0][width_p-1:0] mem_q;
    logic [ptr_width_lp-1:0]       wPtr_q, wPtr_d, wPtrNext;
    logic [ptr_width_lp-1:0]       rPtr_q, rPtr_d, rPtrNext;
    logic                          full_q, full_d;
    logic                          empty;
    logic                          enq;
    logic                          deq;

    assign empty   = (wPtr_q == rPtr_q) && !full_q;
    assign enq     = v_i && !full_q;
    assign deq     = yumi_i && !empty;
    assign ready_o = !full_q;
    assign v_o     = !empty;
    assign data_o  = mem_q[rPtr_q];

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    always_comb begin
        wPtrNext = (wPtr_q == last_ptr_lp) ? '0 : wPtr_q + 1'b1;
        rPtrNext = (rPtr_q == last_ptr_lp) ? '0 : rPtr_q + 1'b1;
    end

    // Next-state for pointers and the full flag; enq+deq together keeps occupancy.
    always_comb begin
        wPtr_d = wPtr_q;
        rPtr_d = rPtr_q;
        full_d = full_q;
        if (enq) begin
            wPtr_d = wPtrNext;
        end
        if (deq) begin
            rPtr_d = rPtrNext;
        end
        if (enq && !deq) begin
            full_d = (wPtrNext == rPtr_q);
        end else if (deq && !enq) begin
            full_d = 1'b0;
        end
    end

    // Pointer and full-flag registers, synchronously cleared.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wPtr_q <= '0;
            rPtr_q <= '0;
            full_q <= 1'b0;
        end else begin
            wPtr_q <= wPtr_d;
            rPtr_q <= rPtr_d;
            full_q <= full_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wPtr_q] <= data_i;
        end
    end

endmodule

module bsg_n_to_1_tagged_fifo #(
    // Default values only; width_p and els_p are meant to be overridden.
    parameter int                       width_p           = 8,
    parameter int                       num_in_p          = 1,
    parameter int                       els_p             = 2,
    parameter logic [num_in_p-1:0]      unbuffered_mask_p = '0,
    localparam int                      tag_width_lp      = `BSG_SAFE_CLOG2(num_in_p)
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic [num_in_p-1:0]                 v_i,
    input  logic [num_in_p-1:0][width_p-1:0]    data_i,
    output logic [num_in_p-1:0]                 ready_o,
    output logic                                v_o,
    output logic [tag_width_lp-1:0]             tag_o,
    output logic [width_p-1:0]                  data_o,
    input  logic                                yumi_i
`ifdef BSG_N_TO_1_TAGGED_FIFO_COUNTERS_EN
    ,output logic [num_in_p-1:0][15:0]          sent_count_o
`endif
);

    typedef enum logic {
        eIdle   = 1'b0,
        eLocked = 1'b1
    } lockState_e;

    localparam logic [tag_width_lp-1:0] last_idx_lp = tag_width_lp'(num_in_p - 1);

    lockState_e                         state_q, state_d;
    logic [tag_width_lp-1:0]            lockIdx_q, lockIdx_d;
    logic [tag_width_lp-1:0]            rrPtr_q, rrPtr_d;
    logic                               justReset_q;
    logic                               outEnable;
    logic [num_in_p-1:0]                headV;
    logic [num_in_p-1:0][width_p-1:0]   headData;
    logic [num_in_p-1:0]                reqV;
    logic [tag_width_lp-1:0]            grantIdx;
    logic [tag_width_lp-1:0]            rrGrant;

    // Outputs and buffered readies are held off during reset and the cycle after it.
    assign outEnable = reset_n_i && !justReset_q;

    // Remembers that the previous edge was a reset edge.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            justReset_q <= 1'b1;
        end else begin
            justReset_q <= 1'b0;
        end
    end

    // Per-channel head: either a private FIFO or the raw input.
    for (genvar i = 0; i < num_in_p; i++) begin : gChan
        localparam logic [tag_width_lp-1:0] idx_lp = tag_width_lp'(i);
        if (unbuffered_mask_p[i]) begin : gUnbuffered
            assign headV[i]    = v_i[i];
            assign headData[i] = data_i[i];
            assign ready_o[i]  = yumi_i && (grantIdx == idx_lp);
        end else begin : gBuffered
            logic fifoReady;
            bsg_fifo_1r1w_small #(
                .width_p (width_p),
                .els_p   (els_p)
            ) fifo (
                .clk_i   (clk_i),
                .reset_i (~reset_n_i),
                .v_i     (v_i[i] && ready_o[i]),
                .ready_o (fifoReady),
                .data_i  (data_i[i]),
                .v_o     (headV[i]),
                .data_o  (headData[i]),
                .yumi_i  (yumi_i && (grantIdx == idx_lp))
            );
            assign ready_o[i] = fifoReady && outEnable;
        end
    end

    assign reqV = headV & {num_in_p{outEnable}};

    // Round-robin pick: first requester at or after the pointer, with wrap.
    always_comb begin
        logic [2*num_in_p-1:0] rotated;
        int                    offset;
        int                    sum;
        rotated = {reqV, reqV} >> rrPtr_q;
        offset  = 0;
        for (int k = num_in_p - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = k;
            end
        end
        sum = int'(rrPtr_q) + offset;
        if (sum >= num_in_p) begin
            sum = sum - num_in_p;
        end
        rrGrant = tag_width_lp'(sum);
    end

    // While locked the grant is pinned so tag/data cannot change under the consumer.
    always_comb begin
        grantIdx = rrGrant;
        v_o      = |reqV;
        if (state_q == eLocked) begin
            grantIdx = lockIdx_q;
            v_o      = reqV[lockIdx_q];
        end
    end

    assign tag_o  = grantIdx;
    assign data_o = headData[grantIdx];

    // Lock FSM and round-robin pointer next-state.
    always_comb begin
        state_d   = state_q;
        lockIdx_d = lockIdx_q;
        rrPtr_d   = rrPtr_q;
        case (state_q)
            eIdle: begin
                if (v_o && !yumi_i) begin
                    state_d   = eLocked;
                    lockIdx_d = grantIdx;
                end
            end
            eLocked: begin
                if (yumi_i) begin
                    state_d = eIdle;
                end
            end
            default: begin
                state_d = eIdle;
            end
        endcase
        if (yumi_i) begin
            rrPtr_d = (grantIdx == last_idx_lp) ? '0 : grantIdx + 1'b1;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= eIdle;
            lockIdx_q <= '0;
            rrPtr_q   <= '0;
        end else begin
            state_q   <= state_d;
            lockIdx_q <= lockIdx_d;
            rrPtr_q   <= rrPtr_d;
        end
    end

`ifdef BSG_N_TO_1_TAGGED_FIFO_COUNTERS_EN
    logic [num_in_p-1:0][15:0] sentCount_q, sentCount_d;

    // Count consumed words per channel, saturating at all-ones.
    always_comb begin
        sentCount_d = sentCount_q;
        for (int i = 0; i < num_in_p; i++) begin
            if (yumi_i && (grantIdx == tag_width_lp'(i)) && (sentCount_q[i] != 16'hFFFF)) begin
                sentCount_d[i] = sentCount_q[i] + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            sentCount_q <= '0;
        end else begin
            sentCount_q <= sentCount_d;
        end
    end

    assign sent_count_o = sentCount_q;
`endif

endmodule

// File: tb/tb_bsg_n_to_1_tagged_fifo.sv
// Scoreboard bench for bsg_n_to_1_tagged_fifo (4 channels, 8-bit, depth 2).
// Instance A is fully buffered; instance B has channel 1 unbuffered.
module tb_bsg_n_to_1_tagged_fifo;

   typedef struct packed {
      logic [1:0] tag;
      logic [7:0] data;
   } expWord_t;

   logic             clk;
   logic             resetN;

   logic [3:0]       vA;
   logic [3:0][7:0]  dataA;
   logic [3:0]       readyA;
   logic             voA;
   logic [1:0]       tagA;
   logic [7:0]       dataOA;
   logic             yumiA;
   logic             yumiEnA;

   logic [3:0]       vB;
   logic [3:0][7:0]  dataB;
   logic [3:0]       readyB;
   logic             voB;
   logic [1:0]       tagB;
   logic [7:0]       dataOB;
   logic             yumiB;
   logic             yumiEnB;

`ifdef BSG_N_TO_1_TAGGED_FIFO_COUNTERS_EN
   logic [3:0][15:0] countA;
   logic [3:0][15:0] countB;
`endif

   expWord_t         expQ[$];
   int               checks;
   int               errors;

   // Consumer takes a word whenever it is enabled and one is offered.
   assign yumiA = yumiEnA && voA;
   assign yumiB = yumiEnB && voB;

   bsg_n_to_1_tagged_fifo #(
      .width_p           (8),
      .num_in_p          (4),
      .els_p             (2),
      .unbuffered_mask_p (4'b0000)
   ) dutA (
      .clk_i     (clk),
      .reset_n_i (resetN),
      .v_i       (vA),
      .data_i    (dataA),
      .ready_o   (readyA),
      .v_o       (voA),
      .tag_o     (tagA),
      .data_o    (dataOA),
      .yumi_i    (yumiA)
`ifdef BSG_N_TO_1_TAGGED_FIFO_COUNTERS_EN
      ,.sent_count_o (countA)
`endif
   );

   bsg_n_to_1_tagged_fifo #(
      .width_p           (8),
      .num_in_p          (4),
      .els_p             (2),
      .unbuffered_mask_p (4'b0010)
   ) dutB (
      .clk_i     (clk),
      .reset_n_i (resetN),
      .v_i       (vB),
      .data_i    (dataB),
      .ready_o   (readyB),
      .v_o       (voB),
      .tag_o     (tagB),
      .data_o    (dataOB),
      .yumi_i    (yumiB)
`ifdef BSG_N_TO_1_TAGGED_FIFO_COUNTERS_EN
      ,.sent_count_o (countB)
`endif
   );

   // Free-running 10ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something wedges.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Monitor: every consumed word is popped from the scoreboard and compared.
   always @(negedge clk) begin
      if (voA && yumiA) begin
         if (expQ.size() == 0) begin
            checkOutput("mon_unexpected_word", {22'd0, tagA, dataOA}, 32'hFFFF_FFFF);
         end else begin
            expWord_t e;
            e = expQ.pop_front();
            checkOutput("mon_tag", 32'(tagA), 32'(e.tag));
            checkOutput("mon_data", 32'(dataOA), 32'(e.data));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expectWord(input logic [1:0] tag, input logic [7:0] data);
      expWord_t e;
      e.tag  = tag;
      e.data = data;
      expQ.push_back(e);
   endtask

   // Reset for one edge, checking outputs during reset and in the cycle after.
   task automatic doReset();
      resetN = 1'b0;
      #1;
      checkOutput("rst_vo_during", 32'(voA), 0);
      checkOutput("rst_ready_during", 32'(readyA), 0);
      tick();
      resetN = 1'b1;
      #1;
      checkOutput("rst_vo_after", 32'(voA), 0);
      checkOutput("rst_ready_after", 32'(readyA), 0);
      tick();
      checkOutput("rst_ready_open", 32'(readyA), 32'hF);
   endtask

   // Present one word on a channel and hold it until accepted.
   task automatic applyStimulus(input int ch, input logic [7:0] d);
      int n;
      vA[ch]    = 1'b1;
      dataA[ch] = d;
      n = 0;
      while (!readyA[ch] && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         checkOutput("push_timeout", 32'(n), 0);
      end
      tick();
      vA[ch] = 1'b0;
   endtask

   // Push one word on every channel in the same cycle.
   task automatic pushAll(input logic [3:0][7:0] d);
      vA    = 4'hF;
      dataA = d;
      checkOutput("pushall_ready", 32'(readyA), 32'hF);
      tick();
      vA = 4'h0;
   endtask

   // Wait (bounded) for the scoreboard to empty, then expect an idle output.
   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      checkOutput(name, 32'(expQ.size()), 0);
      checkOutput("drain_vo_idle", 32'(voA), 0);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      resetN  = 1'b0;
      vA      = '0;
      dataA   = '0;
      vB      = '0;
      dataB   = '0;
      yumiEnA = 1'b0;
      yumiEnB = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Single word: no bypass, then visible next cycle with tag 2.
      doReset();
      yumiEnA = 1'b1;
      expectWord(2'd2, 8'hA5);
      vA[2]    = 1'b1;
      dataA[2] = 8'hA5;
      checkOutput("t1_no_bypass", 32'(voA), 0);
      tick();
      vA[2] = 1'b0;
      checkOutput("t1_vo", 32'(voA), 1);
      checkOutput("t1_tag", 32'(tagA), 2);
      checkOutput("t1_data", 32'(dataOA), 32'hA5);
      tick();
      checkOutput("t1_vo_gone", 32'(voA), 0);

      // Fairness: two words per channel, drained 0,1,2,3,0,1,2,3 back to back.
      doReset();
      yumiEnA = 1'b0;
      pushAll({8'h40, 8'h30, 8'h20, 8'h10});
      pushAll({8'h43, 8'h33, 8'h23, 8'h13});
      checkOutput("t2_all_full", 32'(readyA), 0);
      expectWord(2'd0, 8'h10);
      expectWord(2'd1, 8'h20);
      expectWord(2'd2, 8'h30);
      expectWord(2'd3, 8'h40);
      expectWord(2'd0, 8'h13);
      expectWord(2'd1, 8'h23);
      expectWord(2'd2, 8'h33);
      expectWord(2'd3, 8'h43);
      yumiEnA = 1'b1;
      repeat (8) tick();
      checkOutput("t2_consecutive", 32'(expQ.size()), 0);
      checkOutput("t2_vo_idle", 32'(voA), 0);

      // Lock: channel 3 held while channel 0 fills; pointer then wraps to 0.
      doReset();
      yumiEnA = 1'b0;
      applyStimulus(3, 8'h33);
      checkOutput("t3_tag0", 32'(tagA), 3);
      applyStimulus(0, 8'h01);
      checkOutput("t3_tag1", 32'(tagA), 3);
      checkOutput("t3_data1", 32'(dataOA), 32'h33);
      applyStimulus(0, 8'h02);
      checkOutput("t3_tag2", 32'(tagA), 3);
      checkOutput("t3_data2", 32'(dataOA), 32'h33);
      expectWord(2'd3, 8'h33);
      expectWord(2'd0, 8'h01);
      expectWord(2'd0, 8'h02);
      yumiEnA = 1'b1;
      waitDrain("t3_drain");

      // Backpressure: depth 2, third word waits and is taken after first yumi.
      doReset();
      yumiEnA = 1'b0;
      applyStimulus(1, 8'h11);
      applyStimulus(1, 8'h12);
      vA[1]    = 1'b1;
      dataA[1] = 8'h13;
      checkOutput("t4_ready_full", 32'(readyA[1]), 0);
      tick();
      checkOutput("t4_ready_held", 32'(readyA[1]), 0);
      expectWord(2'd1, 8'h11);
      expectWord(2'd1, 8'h12);
      expectWord(2'd1, 8'h13);
      yumiEnA = 1'b1;
      #1;
      checkOutput("t4_no_fallthrough", 32'(readyA[1]), 0);
      tick();
      checkOutput("t4_ready_reopen", 32'(readyA[1]), 1);
      tick();
      vA[1] = 1'b0;
      waitDrain("t4_drain");

      // Reset mid-stream drops everything; a later ch3 word comes out alone.
      doReset();
      yumiEnA = 1'b0;
      pushAll({8'hD3, 8'hD2, 8'hD1, 8'hD0});
      pushAll({8'hE3, 8'hE2, 8'hE1, 8'hE0});
      checkOutput("t6_full", 32'(readyA), 0);
      checkOutput("t6_vo_before", 32'(voA), 1);
      doReset();
      yumiEnA = 1'b1;
      expectWord(2'd3, 8'h77);
      applyStimulus(3, 8'h77);
      waitDrain("t6_drain");

      // Unbuffered channel 1 on instance B: combinational path and ready.
      vB[1]    = 1'b1;
      dataB[1] = 8'h3C;
      #1;
      checkOutput("t5_ready_no_yumi", 32'(readyB[1]), 0);
      yumiEnB = 1'b1;
      #1;
      checkOutput("t5_vo", 32'(voB), 1);
      checkOutput("t5_tag", 32'(tagB), 1);
      checkOutput("t5_data", 32'(dataOB), 32'h3C);
      checkOutput("t5_ready", 32'(readyB[1]), 1);
      tick();
      vB[1]   = 1'b0;
      yumiEnB = 1'b0;
      #1;
      checkOutput("t5_vo_gone", 32'(voB), 0);

      tick();
      checkOutput("final_queue_empty", 32'(expQ.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bsg_n_to_1_tagged_fifo.md
Name: bsg_n_to_1_tagged_fifo

Overview:
- Merge side of the tagged-channel scheme: each of num_in_p input channels has its own ready/valid FIFO.
- A locked round-robin arbiter then multiplexes the channel heads onto one valid/yumi output stream. Each output word carries the index of its source channel as a tag.
- Sits at the transmit end of a link whose receive end splits the stream back out by tag.
- Each buffered channel is guaranteed els_p words of storage, independent of the other channels.

Parameters:
width_p, "inv", data width per word; must be overridden.
num_in_p, -1, number of input channels; must be >= 1.
els_p, "inv", FIFO entries per buffered channel; must be >= 2.
unbuffered_mask_p, 0, bit i set: channel i has no FIFO and is passed straight through.
tag_width_lp, `BSG_SAFE_CLOG2(num_in_p), tag width (local).

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
reset_n_i  in  1  synchronous, active-low reset.
v_i  in  num_in_p  per-channel input valid.
data_i  in  num_in_p x width_p  per-channel input data.
ready_o  out  num_in_p  per-channel input ready; a word is accepted when v_i[i] & ready_o[i].
v_o  out  1  output valid.
tag_o  out  tag_width_lp  source channel of data_o.
data_o  out  width_p  output data.
yumi_i  in  1  consumer takes the output word this cycle; legal only when v_o=1.

Behaviour:
- Reset (reset_n_i=0 at a clock edge):
  - All FIFOs are emptied; FIFOs are driven with an active-high reset equal to ~reset_n_i.
  - Round-robin pointer is set to 0; lock is cleared.
  - During reset and in the cycle after it: v_o=0 and ready_o=0 on buffered channels.
  - Reset asserted mid-transfer drops all held words; no partial state survives.
- Buffered channel i:
  - Implemented as bsg_fifo_1r1w_small (width_p, els_p).
  - ready_o[i] = FIFO not full.
  - A word enqueued at edge t can appear on v_o no earlier than the cycle after t (no bypass).
  - Full FIFO: ready_o[i]=0.
  - Full FIFO with a dequeue in the same cycle: ready_o[i] stays 0; no fall-through.
- Unbuffered channel i:
  - head valid = v_i[i]; head data = data_i[i].
  - ready_o[i] = grant_i & yumi_i (combinational).
  - The sender must hold v_i[i] and data_i[i] until accepted.
- Arbitration:
  - Request vector = head valid of each channel.
  - When unlocked, grant goes to the first requesting channel at or after the pointer, scanning upward with wrap-around from num_in_p-1 to 0.
- Output: v_o = any request (unlocked) or the locked channel (locked). tag_o = granted index; data_o = granted head data.
- Lock FSM:
  - IDLE: if v_o & ~yumi_i, register the granted index and move to LOCKED.
  - LOCKED: grant is forced to the locked index, so tag_o and data_o stay stable until yumi_i. Higher-priority arrivals do not preempt.
  - On yumi_i in either state: go to IDLE.
- Pointer: on yumi_i, pointer <= granted index + 1, wrapping at num_in_p (not a power-of-2 mask). Otherwise the pointer is unchanged.
- Dequeue: FIFO i is dequeued exactly when yumi_i & (grant==i).
- Simultaneous enqueue and dequeue on one FIFO in one cycle is legal; occupancy is unchanged.
- num_in_p=1: tag_width_lp=1, tag_o=0 always, and the arbiter degenerates to a pass-through.

Optional Feature:
- Macro: BSG_N_TO_1_TAGGED_FIFO_COUNTERS_EN.
- When defined:
  - Adds output port sent_count_o, num_in_p x 16 bits.
  - Entry i counts yumi_i cycles granted to channel i and saturates at 16'hFFFF.
  - All entries reset to 0 with reset_n_i.
  - The counters do not influence arbitration.
- When undefined: the port and the counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Common configuration: num_in_p=4, width_p=8, els_p=2, mask=0 unless stated.
1. Single word: push 8'hA5 on channel 2 at cycle 5 -> v_o=1 at cycle 6 with tag_o=2, data_o=A5. yumi_i at cycle 6 -> v_o=0 at cycle 7.
2. Fairness: all 4 channels hold 2 words each, yumi_i held at 1 -> tags 0,1,2,3,0,1,2,3 on consecutive cycles, then v_o=0.
3. Lock: channel 3 granted with yumi_i=0 for 3 cycles while channel 0 fills -> tag_o stays 3 and data stable. After yumi_i, the next grant is tag 0 (pointer wrapped to 0).
4. Backpressure: yumi_i=0, push 3 words on channel 1 -> ready_o[1] drops after 2 accepts. The third word is held by the sender and accepted after the first yumi_i.
5. Unbuffered: mask=4'b0010, v_i[1]=1 with data 8'h3C, yumi_i=1 -> v_o, tag_o=1, data_o=3C in the same cycle, and ready_o[1]=1 in that cycle.
6. Reset mid-stream: fill all FIFOs, drive reset_n_i=0 for 1 cycle -> v_o=0. Next word pushed on channel 3 is output first (pointer=0, channels 0-2 empty).
